sdram_responder: RTL and testbench

//  Device-side end of the SDRAM bus: decodes controller commands on the sdram_if signal set, tracks per-bank

---
 rtl/sdram_responder_if.sv | 18 +
 rtl/sdram_responder.sv | 185 ++++++++++++++++++
 tb/tb_sdram_responder.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/sdram_responder_if.sv
// Controller-to-device SDRAM command/address bus; dq stays a separate inout port on the device.
interface sdram_responder_if #(
    parameter int unsigned addr_bits = 12,
    parameter int unsigned ba_bits   = 2,
    parameter int unsigned dm_bits   = 1
);
    logic                 cke;
    logic                 csn;
    logic                 rasn;
    logic                 casn;
    logic                 wen;
    logic [addr_bits-1:0] addr;
    logic [ba_bits-1:0]   ba;
    logic [dm_bits-1:0]   dqm;

    modport master (output cke, csn, rasn, casn, wen, addr, ba, dqm);
    modport slave  (input  cke, csn, rasn, casn, wen, addr, ba, dqm);
endinterface

// File: rtl/sdram_responder.sv
// Device-side SDRAM model: decodes commands, tracks open rows and mode, and serves bursts from
// an internal array with CAS latency and DQM; protocol misuse pulses err with a code.
module sdram_responder #(
    parameter int unsigned addr_bits     = 12,
    parameter int unsigned ba_bits       = 2,
    parameter int unsigned dq_bits       = 16,
    parameter int unsigned dm_bits       = 1,
    parameter int unsigned col_bits      = 8,
    parameter int unsigned row_stor_bits = 2
) (
    input  logic               clk,
    input  logic               resetn,
    sdram_responder_if.slave   bus,
    inout  wire  [dq_bits-1:0] dq,
    output logic               err,
    output logic [2:0]         err_code
);
    localparam int unsigned NumBanks = 1 << ba_bits;
    localparam int unsigned MemAw    = ba_bits + row_stor_bits + col_bits;
    localparam int unsigned MemDepth = 1 << MemAw;

    typedef enum logic [2:0] {
        CmdLmr = 3'b000, CmdRef = 3'b001, CmdPre = 3'b010, CmdAct = 3'b011,
        CmdWr  = 3'b100, CmdRd  = 3'b101, CmdBst = 3'b110, CmdNop = 3'b111
    } cmd_e;

    logic [dq_bits-1:0] mem [MemDepth];

    logic [NumBanks-1:0]      bank_open_q;
    logic [row_stor_bits-1:0] bank_row_q [NumBanks];
    logic [1:0]               mode_bl_q;
    logic                     mode_cl3_q;
    logic                     mode_single_q;

    logic                     bst_act_q, bst_wr_q, bst_ap_q;
    logic [ba_bits-1:0]       bst_bank_q;
    logic [row_stor_bits-1:0] bst_row_q;
    logic [col_bits-1:0]      bst_col_q;
    logic [2:0]               bst_idx_q, bst_mask_q;

    logic [1:0]               pipe_v_q;
    logic [dq_bits-1:0]       pipe_d_q [2];
    logic                     out_oe_q;
    logic [dq_bits-1:0]       out_d_q;
    logic                     dqm_q;

    cmd_e cmd;
    logic en, sel, is_act, is_rd, is_wr, is_pre, is_ref, is_lmr, is_bst;
    logic bank_ok, start, lmr_ok, pend, wr_clash, ap_close, mem_we, err_d, unused_addr;
    logic [2:0]               cur_mask, code_d;
    logic [ba_bits-1:0]       beat_bank;
    logic [row_stor_bits-1:0] beat_row;
    logic [col_bits-1:0]      beat_base, beat_col;
    logic [2:0]               beat_idx, beat_mask;
    logic                     beat_v, beat_wr, beat_ap, beat_last;
    logic [MemAw-1:0]         beat_addr;
    logic [dq_bits-1:0]       rd_data;

    assign cmd       = cmd_e'({bus.rasn, bus.casn, bus.wen});
    assign en        = bus.cke;
    assign sel       = en & ~bus.csn;
    assign is_act    = sel & (cmd == CmdAct);
    assign is_rd     = sel & (cmd == CmdRd);
    assign is_wr     = sel & (cmd == CmdWr);
    assign is_pre    = sel & (cmd == CmdPre);
    assign is_ref    = sel & (cmd == CmdRef);
    assign is_lmr    = sel & (cmd == CmdLmr);
    assign is_bst    = sel & (cmd == CmdBst);
    assign bank_ok   = bank_open_q[bus.ba];
    assign start     = (is_rd | is_wr) & bank_ok;
    assign cur_mask  = 3'((4'd1 << mode_bl_q) - 4'd1);
    assign lmr_ok    = ~bus.addr[2] & ~bus.addr[3] &
                       ((bus.addr[6:4] == 3'd2) | (bus.addr[6:4] == 3'd3));
    assign unused_addr = ^bus.addr;

    // Beat 0 comes straight from the command; later beats from the burst registers.
    always_comb begin
        beat_bank = start ? bus.ba : bst_bank_q;
        beat_row  = start ? bank_row_q[bus.ba] : bst_row_q;
        beat_base = start ? bus.addr[col_bits-1:0] : bst_col_q;
        beat_idx  = start ? 3'd0 : bst_idx_q;
        beat_wr   = start ? is_wr : bst_wr_q;
        beat_ap   = start ? bus.addr[10] : bst_ap_q;
        beat_mask = start ? ((is_wr && mode_single_q) ? 3'd0 : cur_mask) : bst_mask_q;
        beat_v    = start | (en & bst_act_q & ~is_bst);
        beat_col  = (beat_base & ~col_bits'(beat_mask)) |
                    ((beat_base + col_bits'(beat_idx)) & col_bits'(beat_mask));
        beat_last = (beat_idx == beat_mask);
        beat_addr = {beat_bank, beat_row, beat_col};
    end

    assign rd_data  = mem[beat_addr];
    assign mem_we   = beat_v & beat_wr & ~(|bus.dqm);
    assign pend     = pipe_v_q[0] | (mode_cl3_q & pipe_v_q[1]);
    assign wr_clash = is_wr & bank_ok & pend;
    assign ap_close = (beat_v & beat_last & beat_ap) | (is_bst & bst_act_q & bst_ap_q);
    assign dq       = out_oe_q ? out_d_q : 'z;

    always_comb begin
        err_d  = 1'b1;
        code_d = err_code;
        if (is_act && bank_ok)                 code_d = 3'd1;
        else if ((is_rd || is_wr) && !bank_ok) code_d = 3'd2;
        else if (is_ref && |bank_open_q)       code_d = 3'd3;
        else if (is_lmr && !lmr_ok)            code_d = 3'd4;
        else if (wr_clash)                     code_d = 3'd5;
        else                                   err_d  = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (mem_we) mem[beat_addr] <= dq;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            bank_open_q   <= '0;
            for (int unsigned b = 0; b < NumBanks; b++) bank_row_q[b] <= '0;
            mode_bl_q     <= 2'd0;
            mode_cl3_q    <= 1'b0;
            mode_single_q <= 1'b0;
            bst_act_q     <= 1'b0;
            bst_wr_q      <= 1'b0;
            bst_ap_q      <= 1'b0;
            bst_bank_q    <= '0;
            bst_row_q     <= '0;
            bst_col_q     <= '0;
            bst_idx_q     <= 3'd0;
            bst_mask_q    <= 3'd0;
            pipe_v_q      <= 2'b00;
            pipe_d_q[0]   <= '0;
            pipe_d_q[1]   <= '0;
            out_oe_q      <= 1'b0;
            out_d_q       <= '0;
            dqm_q         <= 1'b0;
            err           <= 1'b0;
            err_code      <= 3'd0;
        end else if (en) begin
            err <= err_d;
            if (err_d) err_code <= code_d;

            // Output stage uses dqm from the previous edge, giving read DQM latency 2.
            dqm_q       <= |bus.dqm;
            pipe_v_q    <= {pipe_v_q[0], beat_v & ~beat_wr};
            pipe_d_q[0] <= rd_data;
            pipe_d_q[1] <= pipe_d_q[0];
            out_oe_q    <= (mode_cl3_q ? pipe_v_q[1] : pipe_v_q[0]) & ~dqm_q;
            out_d_q     <= mode_cl3_q ? pipe_d_q[1] : pipe_d_q[0];
            if (wr_clash) begin
                pipe_v_q <= 2'b00;
                out_oe_q <= 1'b0;
            end

            if (start) begin
                bst_act_q  <= ~beat_last;
                bst_wr_q   <= is_wr;
                bst_ap_q   <= bus.addr[10];
                bst_bank_q <= bus.ba;
                bst_row_q  <= bank_row_q[bus.ba];
                bst_col_q  <= bus.addr[col_bits-1:0];
                bst_idx_q  <= 3'd1;
                bst_mask_q <= beat_mask;
            end else if (bst_act_q && is_bst) begin
                bst_act_q <= 1'b0;
            end else if (bst_act_q) begin
                bst_idx_q <= bst_idx_q + 3'd1;
                if (beat_last) bst_act_q <= 1'b0;
            end

            for (int unsigned b = 0; b < NumBanks; b++) begin
                if (ap_close && beat_bank == ba_bits'(b)) bank_open_q[b] <= 1'b0;
                if (is_pre && (bus.addr[10] || bus.ba == ba_bits'(b))) bank_open_q[b] <= 1'b0;
                if (is_act && bus.ba == ba_bits'(b) && !bank_open_q[b]) begin
                    bank_open_q[b] <= 1'b1;
                    bank_row_q[b]  <= bus.addr[row_stor_bits-1:0];
                end
            end

            if (is_lmr && lmr_ok) begin
                mode_bl_q     <= bus.addr[1:0];
                mode_cl3_q    <= bus.addr[4];
                mode_single_q <= bus.addr[9];
            end
        end
    end
endmodule

// File: tb/tb_sdram_responder.sv
// Scoreboard bench for sdram_responder: read beats are queued per edge when a READ is issued and
// compared when that edge arrives; a pull-up on dq makes an undriven bus read as all ones.
module tb_sdram_responder;
    localparam logic [2:0]  CLmr = 3'b000, CRef = 3'b001, CAct = 3'b011, CWr = 3'b100;
    localparam logic [2:0]  CRd = 3'b101, CBst = 3'b110, CNop = 3'b111;
    localparam logic [15:0] ZVal = 16'hFFFF;

    typedef struct {
        int          at;
        logic [15:0] val;
    } exp_t;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        tb_oe = 1'b0;
    logic [15:0] tb_dq = 16'h0;
    wire  [15:0] dq;
    logic        err;
    logic [2:0]  err_code;

    exp_t        sb[$];
    logic [15:0] model [int];
    int          rowlo_m [4];
    int          edge_n = 0;
    int          cl_m = 2;
    int          bl_m = 1;
    int          n_checks = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;

    sdram_responder_if bus ();

    assign dq = tb_oe ? tb_dq : 'z;
    pullup pu_dq (dq);

    sdram_responder dut (
        .clk      (clk),
        .resetn   (resetn),
        .bus      (bus),
        .dq       (dq),
        .err      (err),
        .err_code (err_code)
    );

    task automatic check_val(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h (edge %0d)", tag, obs, exp, edge_n);
        end
    endtask

    function automatic int mkey(input int b, input int c);
        return (b << 10) | (rowlo_m[b] << 8) | c;
    endfunction

    function automatic int wcol(input int col, input int i);
        int m;
        m = bl_m - 1;
        return (col & ~m) | ((col + i) & m);
    endfunction

    // One clock edge: drive inputs, sample dq half a cycle before the edge, then advance.
    task automatic step(input logic [2:0] c, input int b, input int a, input logic m,
                        input logic drv, input logic [15:0] d);
        exp_t e;
        bus.csn = 1'b0;
        {bus.rasn, bus.casn, bus.wen} = c;
        bus.ba   = 2'(b);
        bus.addr = 12'(a);
        bus.dqm  = m;
        tb_oe    = drv;
        tb_dq    = d;
        @(negedge clk);
        if (sb.size() > 0 && sb[0].at == edge_n + 1) begin
            e = sb.pop_front();
            check_val("rd_beat", dq, e.val);
        end else if (!drv) begin
            check_val("dq_idle_z", dq, ZVal);
        end
        @(posedge clk);
        #1;
        edge_n++;
    endtask

    task automatic nop();
        step(CNop, 0, 0, 1'b0, 1'b0, 16'h0);
    endtask

    task automatic lmr(input int v);
        step(CLmr, 0, v, 1'b0, 1'b0, 16'h0);
        if (((v >> 2) & 1) == 0 && ((v >> 3) & 1) == 0 &&
            (((v >> 4) & 7) == 2 || ((v >> 4) & 7) == 3)) begin
            bl_m = 1 << (v & 3);
            cl_m = (v >> 4) & 7;
        end
    endtask

    task automatic act(input int b, input int row);
        step(CAct, b, row, 1'b0, 1'b0, 16'h0);
        rowlo_m[b] = row & 3;
    endtask

    task automatic wr_burst(input int b, input int col, input logic [15:0] v0,
                            input logic [7:0] mskb);
        for (int i = 0; i < bl_m; i++) begin
            if (!mskb[i]) model[mkey(b, wcol(col, i))] = v0 + 16'(i);
            step(i == 0 ? CWr : CNop, b, i == 0 ? col : 0, mskb[i], 1'b1, v0 + 16'(i));
        end
    endtask

    // rmask[i] masks beat i; stop > 0 issues BURST TERMINATE after that many beats.
    task automatic rd_burst(input int b, input int col, input int ap, input logic [7:0] rmask,
                            input int stop);
        int   r, nb, bi;
        logic m;
        r  = edge_n + 1;
        nb = (stop > 0) ? stop : bl_m;
        for (int i = 0; i < nb; i++)
            sb.push_back('{at: r + cl_m + i, val: rmask[i] ? ZVal : model[mkey(b, wcol(col, i))]});
        for (int k = 0; k <= nb + cl_m; k++) begin
            bi = k + 2 - cl_m;
            m  = (bi >= 0 && bi < 8) ? rmask[bi] : 1'b0;
            if (k == 0)         step(CRd, b, col | (ap << 10), m, 1'b0, 16'h0);
            else if (k == stop) step(CBst, 0, 0, m, 1'b0, 16'h0);
            else                step(CNop, 0, 0, m, 1'b0, 16'h0);
        end
    endtask

    task automatic expect_err(input string tag, input int code);
        check_val(tag, 16'(err), 16'd1);
        check_val(tag, 16'(err_code), 16'(code));
        nop();
        check_val(tag, 16'(err), 16'd0);
    endtask

    initial begin
        int r;
        bus.cke = 1'b1; bus.csn = 1'b1; bus.rasn = 1'b1; bus.casn = 1'b1; bus.wen = 1'b1;
        bus.addr = '0; bus.ba = '0; bus.dqm = '0;
        repeat (2) @(posedge clk);
        #1;
        check_val("rst_dq_z", dq, ZVal);
        check_val("rst_err", 16'(err), 16'd0);
        check_val("rst_code", 16'(err_code), 16'd0);
        resetn = 1'b1;

        // CL3 BL4 write then read
        lmr(12'h032);
        act(1, 5);
        wr_burst(1, 4, 16'h00A0, 8'h00);
        rd_burst(1, 4, 0, 8'h00, 0);

        // BL4 CL2 wrap from col 6
        lmr(12'h022);
        wr_burst(1, 4, 16'h0010, 8'h00);
        rd_burst(1, 6, 0, 8'h00, 0);

        // write and read DQM
        wr_burst(1, 16, 16'h0030, 8'h00);
        wr_burst(1, 16, 16'h0020, 8'b0000_0010);
        rd_burst(1, 16, 0, 8'b0000_0010, 0);
        rd_burst(1, 16, 0, 8'h00, 0);

        // protocol errors
        step(CRd, 2, 0, 1'b0, 1'b0, 16'h0);
        expect_err("err_rd_closed", 2);
        step(CAct, 1, 7, 1'b0, 1'b0, 16'h0);
        expect_err("err_act_open", 1);
        step(CRef, 0, 0, 1'b0, 1'b0, 16'h0);
        expect_err("err_ref_open", 3);
        lmr(12'h072);
        expect_err("err_bad_mode", 4);
        rd_burst(1, 4, 0, 8'h00, 0);

        // WRITE while read beats are in flight flushes them
        step(CRd, 1, 4, 1'b0, 1'b0, 16'h0);
        step(CWr, 1, 64, 1'b0, 1'b1, 16'h0055);
        expect_err("err_wr_clash", 5);
        repeat (5) nop();

        // BL8 burst terminate, then with auto-precharge
        lmr(12'h023);
        wr_burst(1, 32, 16'h0040, 8'h00);
        rd_burst(1, 32, 0, 8'h00, 3);
        rd_burst(1, 32, 1, 8'h00, 3);
        step(CRd, 1, 32, 1'b0, 1'b0, 16'h0);
        expect_err("err_ap_closed", 2);
        act(1, 5);

        // cke held low for two edges right after the READ
        lmr(12'h022);
        r = edge_n + 1;
        for (int i = 0; i < 4; i++) sb.push_back('{at: r + 4 + i, val: model[mkey(1, 4 + i)]});
        step(CRd, 1, 4, 1'b0, 1'b0, 16'h0);
        bus.cke = 1'b0;
        nop();
        nop();
        bus.cke = 1'b1;
        repeat (6) nop();

        // reset in the middle of a read burst
        r = edge_n + 1;
        for (int i = 0; i < 4; i++) sb.push_back('{at: r + 2 + i, val: model[mkey(1, 4 + i)]});
        step(CRd, 1, 4, 1'b0, 1'b0, 16'h0);
        nop();
        nop();
        resetn = 1'b0;
        #1;
        check_val("rst_mid_dq_z", dq, ZVal);
        check_val("rst_mid_code", 16'(err_code), 16'd0);
        sb.delete();
        nop();
        nop();
        resetn = 1'b1;
        bl_m = 1;
        cl_m = 2;
        step(CRd, 1, 4, 1'b0, 1'b0, 16'h0);
        expect_err("err_rst_closed", 2);
        act(1, 5);
        rd_burst(1, 4, 0, 8'h00, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
